muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 A  input  32  operand rs1.
REQ-007 B  input  32  operand B, driven by the ALU operand-B select path.
REQ-008 flush  input  1  synchronous abort of any operation in flight.
REQ-009 busy  output  1  high from the cycle after acceptance until the cycle after done.
REQ-010 done  output  1  one-cycle pulse; Resultado is valid in that cycle.
REQ-011 Resultado  output  32  result register.

Function
REQ-012 FSM states SHALL be IDLE, CALC, FIX and DONE; busy SHALL be high in every state except IDLE.
REQ-013 start=1 in IDLE SHALL capture op, A and B in the same clock edge; start while busy=1 SHALL be ignored, and the captured operands SHALL NOT change.
REQ-014 IDLE to CALC on acceptance; CALC SHALL run exactly 32 iterations (5-bit counter 0..31); CALC to FIX after iteration 31; FIX to DONE; DONE to IDLE unconditionally.
REQ-015 Normal latency: acceptance at edge N gives done=1 during the cycle after edge N+34; the next start SHALL be accepted at edge N+35 at the earliest.
REQ-016 Multiply SHALL be radix-2 shift-add on 33-bit sign/zero-extended magnitudes, with a 64-bit product; MUL returns bits [31:0], MULH/MULHSU/MULHU return bits [63:32].
REQ-017 Signedness: MULH treats A and B as signed; MULHSU treats A as signed and B as unsigned; MULHU, DIVU and REMU treat both as unsigned.
REQ-018 Divide SHALL be restoring division on absolute values; FIX SHALL negate the quotient when the operand signs differ and SHALL give the remainder the sign of the dividend (signed ops only).
REQ-019 Divide by zero (B=0) SHALL bypass CALC (IDLE to FIX to DONE, done at N+2): quotient 0xFFFFFFFF for DIV/DIVU, remainder = A for REM/REMU.
REQ-020 Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF) SHALL bypass CALC: DIV gives 0x80000000, REM gives 0x00000000, done at N+2.
REQ-021 Resultado SHALL be written only in FIX and SHALL hold its value until the next FIX.
REQ-022 flush=1 in any state SHALL force IDLE at the next edge with no done pulse; Resultado SHALL keep its previous value; flush has priority over start in the same cycle.
REQ-023 done SHALL be a registered output (high only in DONE) and SHALL never stay high for two consecutive cycles.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, Resultado=0x00000000, iteration counter=0, and clear all internal operand registers.
REQ-025 Reset asserted mid-CALC SHALL abort with no done pulse; after release the first start SHALL behave as from power-up.
REQ-026 Release of rst_n SHALL take effect at the first clk edge with rst_n=1; start sampled at that edge SHALL be accepted.

Verification
REQ-027 MUL A=0xFFFFFFFF B=0x00000002 -> done at N+35, Resultado=0xFFFFFFFE; MULHU with the same operands -> 0x00000001; MULH -> 0xFFFFFFFF.
REQ-028 DIV A=0xFFFFFFF9 (-7) B=0x00000002 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU -> 0x7FFFFFFC; all with 35-cycle latency.
REQ-029 DIVU A=0x00000005 B=0 -> done at N+2, Resultado=0xFFFFFFFF; REMU -> 0x00000005; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at N+2.
REQ-030 start with MUL 3*4, then start re-pulsed at N+10 with A=9 -> single done, Resultado=0x0000000C.
REQ-031 flush at N+15 during a DIV -> busy=0 at N+16, no done, Resultado unchanged; a new MUL 2*3 then gives 0x00000006.
REQ-032 rst_n low for 1 cycle at N+20 during a MULHSU -> outputs zero immediately, no done; a later op completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring divider
// sharing one iterative datapath, with a sign-fixup state ahead of the result register.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] Resultado
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [2:0] OP_MUL = 3'b000;

    state_t      state, state_nx;
    logic [2:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  cnt;
    logic        primed;
    logic [63:0] acc, sh;
    logic [31:0] mpl;

    logic        accept, bypass_in;
    logic        sa, sb, neg_a, neg_b;
    logic [31:0] mag_a, mag_b;
    logic [32:0] rem_sh;
    logic        trial_ok;

    function automatic logic [31:0] fix_result(
        input logic [2:0]  o,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [63:0] ac,
        input logic [31:0] q,
        input logic        na,
        input logic        nb
    );
        logic [63:0] p;
        logic [31:0] qq, rr;
        logic        sgn;
        p   = (na ^ nb) ? -ac : ac;
        qq  = (na ^ nb) ? -q : q;
        rr  = na ? -ac[31:0] : ac[31:0];
        sgn = !o[0];
        if (!o[2]) begin
            fix_result = (o == OP_MUL) ? p[31:0] : p[63:32];
        end else if (b == 32'h0) begin
            fix_result = o[1] ? a : 32'hFFFF_FFFF;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            fix_result = o[1] ? 32'h0000_0000 : 32'h8000_0000;
        end else begin
            fix_result = o[1] ? rr : qq;
        end
    endfunction

    assign busy   = (state != IDLE);
    assign accept = (state == IDLE) && start && !flush;

    // Divide-by-zero and signed overflow are fully determined by the operands, so skip CALC.
    assign bypass_in = op[2] && ((B == 32'h0) ||
                       (!op[0] && A == 32'h8000_0000 && B == 32'hFFFF_FFFF));

    assign sa    = op_q[2] ? !op_q[0] : (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10);
    assign sb    = op_q[2] ? !op_q[0] : (op_q[1:0] == 2'b01);
    assign neg_a = sa & a_q[31];
    assign neg_b = sb & b_q[31];
    assign mag_a = neg_a ? (~a_q + 32'd1) : a_q;
    assign mag_b = neg_b ? (~b_q + 32'd1) : b_q;

    assign rem_sh   = {acc[31:0], mpl[31]};
    assign trial_ok = (rem_sh >= {1'b0, sh[31:0]});

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = bypass_in ? FIX : CALC;
            CALC:    if (primed && cnt == 5'd31) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // First CALC cycle loads magnitudes; the following 32 perform one step each.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt       <= '0;
            primed    <= 1'b0;
            acc       <= '0;
            sh        <= '0;
            mpl       <= '0;
            done      <= 1'b0;
            Resultado <= '0;
        end else begin
            done <= (state_nx == DONE);
            if (accept) begin
                op_q   <= op;
                a_q    <= A;
                b_q    <= B;
                cnt    <= '0;
                primed <= 1'b0;
            end else if (state == CALC && !flush) begin
                if (!primed) begin
                    primed <= 1'b1;
                    acc    <= '0;
                    if (op_q[2]) begin
                        sh  <= {32'h0, mag_b};
                        mpl <= mag_a;
                    end else begin
                        sh  <= {32'h0, mag_a};
                        mpl <= mag_b;
                    end
                end else begin
                    cnt <= cnt + 5'd1;
                    if (op_q[2]) begin
                        acc <= trial_ok ? {31'h0, rem_sh - {1'b0, sh[31:0]}} : {31'h0, rem_sh};
                        mpl <= {mpl[30:0], trial_ok};
                    end else begin
                        if (mpl[0]) acc <= acc + sh;
                        sh  <= {sh[62:0], 1'b0};
                        mpl <= {1'b0, mpl[31:1]};
                    end
                end
            end
            if (state == FIX && !flush)
                Resultado <= fix_result(op_q, a_q, b_q, acc, mpl, neg_a, neg_b);
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, bypass paths, flush, reset and ignored starts.
module tb_muldiv_unit;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] A = 32'h0, B = 32'h0;
    logic        busy, done;
    logic [31:0] Resultado;

    int n_cmp = 0, n_bad = 0, done_cnt = 0;
    int c0, lat;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .flush(flush), .busy(busy), .done(done), .Resultado(Resultado)
    );

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int l);
        l = from;
        while (done !== 1'b1 && l < 60) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int l;
        launch(o, a, b);
        check({tag, ":busy"}, {31'h0, busy}, 32'h1);
        wait_done(0, l);
        check({tag, ":lat"}, 32'(l), 32'(exp_lat));
        check(tag, Resultado, exp);
        @(posedge clk); #1;
        check({tag, ":pulse"}, {31'h0, done}, 32'h0);
        check({tag, ":idle"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_res", Resultado, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run("mul",    MUL,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 34);
        run("mulhu",  MULHU,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 34);
        run("mulh",   MULH,   32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34);
        run("mulh2",  MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run("mulhu2", MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run("mulhsu", MULHSU, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE, 34);
        run("div",    DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34);
        run("rem",    REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34);
        run("divu",   DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 34);
        run("remu",   REMU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 34);
        run("div_nb", DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
        run("rem_nb", REM,    32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 34);

        run("divu_z", DIVU,   32'h0000_0005, 32'h0,         32'hFFFF_FFFF, 1);
        run("remu_z", REMU,   32'h0000_0005, 32'h0,         32'h0000_0005, 1);
        run("div_z",  DIV,    32'h0000_0005, 32'h0,         32'hFFFF_FFFF, 1);
        run("rem_z",  REM,    32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 1);
        run("div_ov", DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ov", REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

        // start re-pulsed while busy must be ignored
        c0 = done_cnt;
        launch(MUL, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        op = DIV; A = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(10, lat);
        check("restart:lat", 32'(lat), 32'd34);
        check("restart", Resultado, 32'h0000_000C);
        repeat (40) @(posedge clk);
        #1;
        check("restart:ndone", 32'(done_cnt - c0), 32'd1);
        check("restart:hold", Resultado, 32'h0000_000C);

        // flush mid-divide
        launch(DIV, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush:busy", {31'h0, busy}, 32'h0);
        check("flush:res", Resultado, 32'h0000_000C);
        c0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("flush:ndone", 32'(done_cnt - c0), 32'd0);
        check("flush:hold", Resultado, 32'h0000_000C);
        run("mul23", MUL, 32'd2, 32'd3, 32'h0000_0006, 34);

        // flush beats start in IDLE
        op = MUL; A = 32'd7; B = 32'd7; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flushprio", {31'h0, busy}, 32'h0);

        // async reset mid-MULHSU, then start on the release edge
        launch(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (19) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst:res", Resultado, 32'h0);
        check("arst:busy", {31'h0, busy}, 32'h0);
        check("arst:done", {31'h0, done}, 32'h0);
        c0 = done_cnt;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run("post_rst", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
        check("arst:ndone", 32'(done_cnt - c0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
